// File: rtl/mcycle_ctrl.sv
// Multi-cycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing,
// memory wait timeout, sticky status flags and a retired-instruction counter.
module mcycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_opcode,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output logic        o_pc_write,
  output logic        o_ir_write,
  output logic        o_reg_wen,
  output logic        o_mem_wen,
  output logic        o_mem_ren,
  output logic        o_alu_src,
  output logic        o_reg_dst,
  output logic        o_mem_to_reg,
  output logic        o_pc_src,
  output logic [2:0]  o_aluop,
  output logic [2:0]  o_state,
  output logic        o_halted,
  output logic        o_illegal,
  output logic        o_mem_err,
  output logic [15:0] o_instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t      r_state;
  logic [3:0]  r_op;
  logic [3:0]  r_wait;
  logic [15:0] r_count;
  logic        r_pc_write, r_ir_write, r_reg_wen, r_mem_wen, r_mem_ren;
  logic        r_alu_src, r_mem_to_reg, r_pc_src_en;
  logic [2:0]  r_aluop;
  logic        r_halted, r_illegal, r_mem_err;

  logic [3:0]  w_op;
  logic        w_is_mem;
  logic        w_in_instr;

  // The IR is loaded on the FETCH edge, so the opcode is only usable from
  // DECODE on; DECODE sees it live, later states use the latched copy.
  assign w_op       = (r_state == S_DECODE) ? i_opcode : r_op;
  assign w_is_mem   = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_in_instr = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                      (r_state == S_MEM)    || (r_state == S_WB);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_FETCH;
      r_op         <= 4'h0;
      r_wait       <= 4'h0;
      r_count      <= 16'h0;
      r_pc_write   <= 1'b1;
      r_ir_write   <= 1'b1;
      r_reg_wen    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_ren    <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_pc_src_en  <= 1'b0;
      r_aluop      <= 3'd0;
      r_halted     <= 1'b0;
      r_illegal    <= 1'b0;
      r_mem_err    <= 1'b0;
    end else begin
      r_pc_write   <= 1'b0;
      r_ir_write   <= 1'b0;
      r_reg_wen    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_ren    <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_pc_src_en  <= 1'b0;
      r_aluop      <= 3'd0;
      case (r_state)
        S_FETCH: begin
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_op <= i_opcode;
          if (i_opcode == OP_HALT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (i_opcode >= 4'hC) begin
            r_state    <= S_FETCH;
            r_illegal  <= 1'b1;
            r_count    <= r_count + 16'd1;
            r_pc_write <= 1'b1;
            r_ir_write <= 1'b1;
          end else begin
            r_state <= S_EXEC;
            if (!i_opcode[3]) begin
              r_aluop <= i_opcode[2:0];
            end else if (i_opcode == OP_BEQ) begin
              r_aluop     <= 3'b001;
              r_pc_write  <= 1'b1;
              r_pc_src_en <= 1'b1;
            end else begin
              r_alu_src <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          r_wait <= 4'h0;
          if (r_op == OP_BEQ) begin
            r_state    <= S_FETCH;
            r_count    <= r_count + 16'd1;
            r_pc_write <= 1'b1;
            r_ir_write <= 1'b1;
          end else if (r_op == OP_LW) begin
            r_state   <= S_MEM;
            r_mem_ren <= 1'b1;
          end else if (r_op == OP_SW) begin
            r_state   <= S_MEM;
            r_mem_wen <= 1'b1;
          end else begin
            r_state      <= S_WB;
            r_reg_wen    <= 1'b1;
            r_mem_to_reg <= 1'b1;
          end
        end
        S_MEM: begin
          if (i_mem_ready) begin
            r_wait <= 4'h0;
            if (r_op == OP_LW) begin
              r_state   <= S_WB;
              r_reg_wen <= 1'b1;
            end else begin
              r_state    <= S_FETCH;
              r_count    <= r_count + 16'd1;
              r_pc_write <= 1'b1;
              r_ir_write <= 1'b1;
            end
          end else if (r_wait == WAIT_LAST) begin
            r_wait    <= 4'h0;
            r_state   <= S_HALT;
            r_halted  <= 1'b1;
            r_mem_err <= 1'b1;
          end else begin
            r_wait    <= r_wait + 4'd1;
            r_mem_ren <= (r_op == OP_LW);
            r_mem_wen <= (r_op == OP_SW);
          end
        end
        S_WB: begin
          r_state    <= S_FETCH;
          r_count    <= r_count + 16'd1;
          r_pc_write <= 1'b1;
          r_ir_write <= 1'b1;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state    <= S_FETCH;
          r_pc_write <= 1'b1;
          r_ir_write <= 1'b1;
        end
      endcase
    end
  end

  assign o_pc_write    = r_pc_write;
  assign o_ir_write    = r_ir_write;
  assign o_reg_wen     = r_reg_wen;
  assign o_mem_wen     = r_mem_wen;
  assign o_mem_ren     = r_mem_ren;
  assign o_alu_src     = r_alu_src;
  assign o_reg_dst     = w_in_instr && w_is_mem;
  assign o_mem_to_reg  = r_mem_to_reg;
  // Branch target select follows the live ALU zero flag during EXEC.
  assign o_pc_src      = r_pc_src_en && i_zero;
  assign o_aluop       = r_aluop;
  assign o_state       = r_state;
  assign o_halted      = r_halted;
  assign o_illegal     = r_illegal;
  assign o_mem_err     = r_mem_err;
  assign o_instr_count = r_count;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Self-checking bench for mcycle_ctrl: directed scenarios plus random
// instruction streams compared cycle by cycle against a per-instruction model.
module tb_mcycle_ctrl;
  localparam int TO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [3:0]  i_opcode = 4'h0;
  logic        i_zero = 1'b0;
  logic        i_mem_ready = 1'b0;
  logic        o_pc_write, o_ir_write, o_reg_wen, o_mem_wen, o_mem_ren;
  logic        o_alu_src, o_reg_dst, o_mem_to_reg, o_pc_src;
  logic [2:0]  o_aluop, o_state;
  logic        o_halted, o_illegal, o_mem_err;
  logic [15:0] o_instr_count;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_count;
  logic        m_halted, m_illegal, m_err;

  mcycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_zero(i_zero),
    .i_mem_ready(i_mem_ready),
    .o_pc_write(o_pc_write), .o_ir_write(o_ir_write), .o_reg_wen(o_reg_wen),
    .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren), .o_alu_src(o_alu_src),
    .o_reg_dst(o_reg_dst), .o_mem_to_reg(o_mem_to_reg), .o_pc_src(o_pc_src),
    .o_aluop(o_aluop), .o_state(o_state), .o_halted(o_halted),
    .o_illegal(o_illegal), .o_mem_err(o_mem_err), .o_instr_count(o_instr_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] e(input logic [2:0] st, input logic pcw, input logic irw,
                                    input logic rwen, input logic mwen, input logic mren,
                                    input logic asrc, input logic rdst, input logic m2r,
                                    input logic psrc, input logic [2:0] aluop);
    return {st, pcw, irw, rwen, mwen, mren, asrc, rdst, m2r, psrc, aluop};
  endfunction

  // Called just after a falling edge with this cycle's inputs already driven.
  task automatic step_check(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    #1;
    obs = {o_state, o_pc_write, o_ir_write, o_reg_wen, o_mem_wen, o_mem_ren,
           o_alu_src, o_reg_dst, o_mem_to_reg, o_pc_src, o_aluop};
    check({tag, "_sig"}, 32'({obs, o_halted, o_illegal, o_mem_err}),
          32'({exp, m_halted, m_illegal, m_err}));
    check({tag, "_cnt"}, 32'(o_instr_count), 32'(m_count));
    @(negedge i_clk);
  endtask

  task automatic noise();
    i_zero      = 1'($urandom);
    i_mem_ready = 1'($urandom);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    noise();
    i_opcode = 4'($urandom);
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_cnt", 32'(o_instr_count), 32'd0);
    check("rst_flags", 32'({o_halted, o_illegal, o_mem_err}), 32'd0);
    check("rst_wr", 32'({o_reg_wen, o_mem_wen, o_mem_ren}), 32'd0);
    i_rst = 1'b0;
    m_count = 16'h0; m_halted = 1'b0; m_illegal = 1'b0; m_err = 1'b0;
  endtask

  // One instruction; w = number of mem_ready-low MEM cycles (>= TO means timeout),
  // zsel < 0 means random zero flag, halt_cycles = HALT cycles observed afterwards.
  task automatic run_instr(input logic [3:0] op, input int w, input int zsel, input int halt_cycles);
    logic rtype, addi, lw, sw, beq, ill, hlt, mem, z, rdy;
    logic [2:0] aop;
    bit done;
    rtype = (op <= 4'h7); addi = (op == 4'h8); lw = (op == 4'h9); sw = (op == 4'hA);
    beq = (op == 4'hB); hlt = (op == 4'hF); ill = (op >= 4'hC) && !hlt;
    mem = lw || sw;

    i_opcode = 4'($urandom); noise();
    step_check("fetch", e(3'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd0));
    i_opcode = op; noise();
    step_check("decode", e(3'd1, 0, 0, 0, 0, 0, 0, mem, 0, 0, 3'd0));
    if (ill) begin
      m_illegal = 1'b1; m_count++;
      return;
    end
    if (hlt) begin
      m_halted = 1'b1;
      repeat (halt_cycles) begin
        noise(); i_opcode = 4'($urandom);
        step_check("halt", e(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
      end
      return;
    end
    z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
    i_zero = z; i_mem_ready = 1'($urandom);
    aop = rtype ? op[2:0] : (beq ? 3'b001 : 3'b000);
    step_check("exec", e(3'd2, beq, 0, 0, 0, 0, addi || mem, mem, 0, beq && z, aop));
    if (beq) begin
      m_count++;
      return;
    end
    if (mem) begin
      done = 0;
      for (int k = 0; k < TO; k++) begin
        rdy = (k == w);
        i_mem_ready = rdy; i_zero = 1'($urandom);
        step_check("mem", e(3'd3, 0, 0, 0, sw, lw, 0, 1, 0, 0, 3'd0));
        if (rdy) begin
          done = 1;
          break;
        end
      end
      if (!done) begin
        m_err = 1'b1; m_halted = 1'b1;
        repeat (halt_cycles) begin
          noise(); i_opcode = 4'($urandom);
          step_check("halt_to", e(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        end
        return;
      end
      if (sw) begin
        m_count++;
        return;
      end
    end
    noise();
    step_check("wb", e(3'd4, 0, 0, 1, 0, 0, 0, lw, !lw, 0, 3'd0));
    m_count++;
  endtask

  task automatic mid_mem_reset();
    i_opcode = 4'($urandom); noise();
    step_check("ab_fetch", e(3'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd0));
    i_opcode = 4'h9; noise();
    step_check("ab_decode", e(3'd1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'd0));
    i_zero = 1'($urandom); i_mem_ready = 1'($urandom);
    step_check("ab_exec", e(3'd2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3'd0));
    i_mem_ready = 1'b0;
    step_check("ab_mem", e(3'd3, 0, 0, 0, 0, 1, 0, 1, 0, 0, 3'd0));
    do_reset();
  endtask

  initial begin
    logic [3:0] op;
    int w, hc;
    m_count = 16'h0; m_halted = 1'b0; m_illegal = 1'b0; m_err = 1'b0;
    @(negedge i_clk);
    do_reset();

    run_instr(4'h0, 0, -1, 0);
    run_instr(4'h9, 2, -1, 0);
    run_instr(4'hB, 0, 1, 0);
    run_instr(4'hB, 0, 0, 0);
    run_instr(4'h8, 0, -1, 0);
    run_instr(4'h5, 0, -1, 0);
    run_instr(4'hA, 0, -1, 0);
    run_instr(4'hA, TO - 1, -1, 0);
    run_instr(4'h9, TO - 1, -1, 0);
    run_instr(4'hD, 0, -1, 0);
    run_instr(4'hF, 0, -1, 20);
    do_reset();
    run_instr(4'hA, 99, -1, 3);
    do_reset();
    run_instr(4'h9, 99, -1, 2);
    do_reset();
    mid_mem_reset();
    run_instr(4'h3, 0, -1, 0);

    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h2;
      case ($urandom_range(0, 9))
        0: w = TO;
        1: w = TO - 1;
        default: w = $urandom_range(0, 3);
      endcase
      hc = $urandom_range(1, 3);
      run_instr(op, w, -1, hc);
      if (m_halted) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
